// File: rtl/traffic_light_monitor.sv
// Receiver-side checker for the four signal heads of a four-way intersection.
// Locks onto the N->S->E->W phase sequence, latches the first violation, counts rounds.
module traffic_light_monitor #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    input  logic       clr_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       in_sync,
    output logic [7:0] round_count
);

    typedef enum logic [1:0] {StSync, StTrack, StFault} state_e;

    // Phase word {valid, dir[1:0], yellow}; all-zero means no single active head.
    localparam logic [3:0] PhNone    = 4'b0000;
    localparam logic [3:0] PhYellowW = 4'b1111;
    localparam logic [3:0] LimGreen  = 4'(GREEN_CYC);
    localparam logic [3:0] LimYellow = 4'(YELLOW_CYC);

    localparam logic [2:0] CodeNone     = 3'b000;
    localparam logic [2:0] CodeIllegal  = 3'b001;
    localparam logic [2:0] CodeConflict = 3'b010;
    localparam logic [2:0] CodeShort    = 3'b011;
    localparam logic [2:0] CodeLong     = 3'b100;
    localparam logic [2:0] CodeSequence = 3'b101;
    localparam logic [2:0] CodeAllRed   = 3'b110;

    state_e     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] dwell_q, dwell_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [1:0] dir_q, dir_d;
    logic       in_sync_q, in_sync_d;
    logic [7:0] round_q, round_d;

    logic [3:0][2:0] heads;
    logic            illegal;
    logic [1:0]      illegal_dir;
    logic [2:0]      nonred_cnt;
    logic [1:0]      nonred_dir;
    logic [3:0]      cur_phase;
    logic            viol;
    logic [2:0]      viol_code;
    logic [1:0]      viol_dir;

    assign heads = {w_lights, e_lights, s_lights, n_lights};

    function automatic logic [3:0] limit_of(input logic [3:0] ph);
        return ph[0] ? LimYellow : LimGreen;
    endfunction

    function automatic logic [3:0] successor(input logic [3:0] ph);
        logic [1:0] next_dir;
        next_dir = ph[2:1] + 2'd1;
        return ph[0] ? {1'b1, next_dir, 1'b0} : {1'b1, ph[2:1], 1'b1};
    endfunction

    // Descending scan so the lowest-index head wins both direction reports.
    always_comb begin
        illegal     = 1'b0;
        illegal_dir = 2'd0;
        nonred_cnt  = 3'd0;
        nonred_dir  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!(heads[i] inside {3'b001, 3'b010, 3'b100})) begin
                illegal     = 1'b1;
                illegal_dir = 2'(i);
            end
            if (heads[i] != 3'b100) begin
                nonred_cnt = nonred_cnt + 3'd1;
                nonred_dir = 2'(i);
            end
        end
        cur_phase = PhNone;
        if (nonred_cnt == 3'd1) begin
            cur_phase = {1'b1, nonred_dir, heads[nonred_dir] == 3'b010};
        end
    end

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        dwell_d   = dwell_q;
        fault_d   = fault_q;
        code_d    = code_q;
        dir_d     = dir_q;
        round_d   = round_q;
        viol      = 1'b0;
        viol_code = CodeNone;
        viol_dir  = 2'd0;

        unique case (state_q)
            StSync, StTrack: begin
                if (illegal) begin
                    viol      = 1'b1;
                    viol_code = CodeIllegal;
                    viol_dir  = illegal_dir;
                end else if (nonred_cnt > 3'd1) begin
                    viol      = 1'b1;
                    viol_code = CodeConflict;
                    viol_dir  = nonred_dir;
                end else if (state_q == StTrack) begin
                    if (cur_phase == PhNone) begin
                        viol      = 1'b1;
                        viol_code = CodeAllRed;
                        viol_dir  = prev_q[2:1];
                    end else if (cur_phase == prev_q) begin
                        if (dwell_q >= limit_of(prev_q)) begin
                            viol      = 1'b1;
                            viol_code = CodeLong;
                            viol_dir  = cur_phase[2:1];
                        end else begin
                            dwell_d = dwell_q + 4'd1;
                        end
                    end else if (dwell_q != limit_of(prev_q)) begin
                        viol      = 1'b1;
                        viol_code = CodeShort;
                        viol_dir  = prev_q[2:1];
                    end else if (cur_phase != successor(prev_q)) begin
                        viol      = 1'b1;
                        viol_code = CodeSequence;
                        viol_dir  = cur_phase[2:1];
                    end else begin
                        prev_d  = cur_phase;
                        dwell_d = 4'd1;
                        if (prev_q == PhYellowW && round_q != 8'hFF) begin
                            round_d = round_q + 8'd1;
                        end
                    end
                end else begin
                    prev_d = cur_phase;
                    if (cur_phase[3] && !cur_phase[0] && prev_q != PhNone &&
                        cur_phase != prev_q) begin
                        state_d = StTrack;
                        dwell_d = 4'd1;
                    end
                end
                if (viol) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                    code_d  = viol_code;
                    dir_d   = viol_dir;
                end
            end
            StFault: begin
                if (clr_fault) begin
                    state_d = StSync;
                    fault_d = 1'b0;
                    code_d  = CodeNone;
                    dir_d   = 2'd0;
                    prev_d  = PhNone;
                    dwell_d = 4'd0;
                    round_d = 8'd0;
                end
            end
            default: state_d = StSync;
        endcase

        in_sync_d = (state_d == StTrack);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= StSync;
            prev_q    <= PhNone;
            dwell_q   <= 4'd0;
            fault_q   <= 1'b0;
            code_q    <= CodeNone;
            dir_q     <= 2'd0;
            in_sync_q <= 1'b0;
            round_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            dwell_q   <= dwell_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            dir_q     <= dir_d;
            in_sync_q <= in_sync_d;
            round_q   <= round_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign fault_dir   = dir_q;
    assign in_sync     = in_sync_q;
    assign round_count = round_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios plus randomized glitches,
// expected outputs from a phase-index reference model.
module tb_traffic_light_monitor;

    localparam int GREEN_CYC  = 8;
    localparam int YELLOW_CYC = 4;
    localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic       in_sync;
    logic [7:0] round_count;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .GREEN_CYC (GREEN_CYC),
        .YELLOW_CYC(YELLOW_CYC)
    ) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .n_lights   (n_lights),
        .s_lights   (s_lights),
        .e_lights   (e_lights),
        .w_lights   (w_lights),
        .clr_fault  (clr_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_dir  (fault_dir),
        .in_sync    (in_sync),
        .round_count(round_count)
    );

    int checks = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    bit          mon_en = 0;
    logic [14:0] mon_exp, mon_got;

    // Model: phase index p = 2*dir + yellow, legal successor is (p+1) mod 8; -1 = none.
    int m_state;  // 0 sync, 1 track, 2 fault
    int m_prev, m_dwell, m_round, m_code, m_dir;
    bit m_fault;

    int ctrl_pos, ctrl_cnt;
    int r;
    logic c;
    logic [11:0] hv;

    function automatic int lim_of(input int pos);
        return (pos % 2 == 1) ? YELLOW_CYC : GREEN_CYC;
    endfunction

    function automatic logic [14:0] model_out();
        return {m_fault, 3'(m_code), 2'(m_dir), (m_state == 1), 8'(m_round)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = -1; m_dwell = 0; m_round = 0;
        m_code = 0; m_dir = 0; m_fault = 0;
    endtask

    task automatic model_step(input bit clr, input logic [11:0] hin);
        int h[4];
        int ill, nr, nrd, cur, vc, vd;
        bit viol;
        ill = -1; nr = 0; nrd = -1; cur = -1; viol = 0; vc = 0; vd = 0;
        if (m_state == 2) begin
            if (clr) model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            h[i] = int'(hin[3*i +: 3]);
            if (h[i] != 1 && h[i] != 2 && h[i] != 4 && ill < 0) ill = i;
            if (h[i] != 4) begin
                nr++;
                if (nrd < 0) nrd = i;
            end
        end
        if (nr == 1) cur = 2 * nrd + ((h[nrd] == 2) ? 1 : 0);
        if (ill >= 0) begin
            viol = 1; vc = 1; vd = ill;
        end else if (nr > 1) begin
            viol = 1; vc = 2; vd = nrd;
        end else if (m_state == 1) begin
            if (nr == 0) begin
                viol = 1; vc = 6; vd = m_prev / 2;
            end else if (cur == m_prev) begin
                if (m_dwell + 1 > lim_of(m_prev)) begin
                    viol = 1; vc = 4; vd = cur / 2;
                end else begin
                    m_dwell++;
                end
            end else if (m_dwell != lim_of(m_prev)) begin
                viol = 1; vc = 3; vd = m_prev / 2;
            end else if (cur != (m_prev + 1) % 8) begin
                viol = 1; vc = 5; vd = cur / 2;
            end else begin
                if (m_prev == 7 && m_round < 255) m_round++;
                m_prev = cur;
                m_dwell = 1;
            end
        end else begin
            if (cur >= 0 && cur % 2 == 0 && m_prev >= 0 && cur != m_prev) begin
                m_state = 1;
                m_dwell = 1;
            end
            m_prev = cur;
        end
        if (viol) begin
            m_state = 2; m_fault = 1; m_code = vc; m_dir = vd;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One sample: drive at negedge, queue expectation, return just after the sampling edge.
    task automatic step(input logic rst, input logic clr, input logic [11:0] hin);
        @(negedge clk);
        rst_a = rst;
        clr_fault = clr;
        {w_lights, e_lights, s_lights, n_lights} = hin;
        if (!rst) model_reset();
        else model_step(clr, hin);
        exp_q.push_back(model_out());
        mon_en = 1;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [11:0] ctrl_heads(input int pos);
        logic [11:0] v;
        int d;
        v = ALL_RED;
        d = pos / 2;
        v[3*d +: 3] = (pos % 2 == 1) ? 3'b010 : 3'b001;
        return v;
    endfunction

    task automatic ctrl_advance();
        ctrl_cnt++;
        if (ctrl_cnt >= lim_of(ctrl_pos)) begin
            ctrl_pos = (ctrl_pos + 1) % 8;
            ctrl_cnt = 0;
        end
    endtask

    task automatic legal();
        step(1'b1, 1'b0, ctrl_heads(ctrl_pos));
        ctrl_advance();
    endtask

    task automatic wait_track_at(input int pos, input int cnt, input string name);
        int n;
        n = 0;
        while (!(m_state == 1 && ctrl_pos == pos && ctrl_cnt == cnt) && n < 300) begin
            legal();
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no lock in %0d cycles, expected lock", name, n);
        end else begin
            chk({name, "_in_sync"}, int'(in_sync), 1);
        end
    endtask

    task automatic clr_pulse(input logic [11:0] hin, input string name);
        step(1'b1, 1'b1, hin);
        ctrl_advance();
        chk({name, "_fault"}, int'(fault), 0);
        chk({name, "_code"}, int'(fault_code), 0);
        chk({name, "_dir"}, int'(fault_dir), 0);
        chk({name, "_in_sync"}, int'(in_sync), 0);
        chk({name, "_rounds"}, int'(round_count), 0);
    endtask

    task automatic chk_fault(input string name, input int code, input int dir);
        chk({name, "_fault"}, int'(fault), 1);
        chk({name, "_code"}, int'(fault_code), code);
        chk({name, "_dir"}, int'(fault_dir), dir);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {fault, fault_code, fault_dir, in_sync, round_count};
            checks++;
            if (mon_got !== mon_exp) begin
                failures++;
                $display("FAIL scoreboard t=%0t: got fault=%0d code=%0d dir=%0d sync=%0d rounds=%0d, expected fault=%0d code=%0d dir=%0d sync=%0d rounds=%0d",
                         $time, mon_got[14], mon_got[13:11], mon_got[10:9], mon_got[8],
                         mon_got[7:0], mon_exp[14], mon_exp[13:11], mon_exp[10:9],
                         mon_exp[8], mon_exp[7:0]);
            end
        end else if (mon_en) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow t=%0t: got output with no expectation queued",
                     $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by t=%0t, expected earlier finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1;
        clr_fault = 1'b0;
        {w_lights, e_lights, s_lights, n_lights} = ALL_RED;
        model_reset();
        #1;
        rst_a = 1'b0;
        #1;
        chk("reset_fault", int'(fault), 0);
        chk("reset_code", int'(fault_code), 0);
        chk("reset_in_sync", int'(in_sync), 0);
        chk("reset_rounds", int'(round_count), 0);
        repeat (3) step(1'b0, 1'b0, ALL_RED);

        // Co-reset with a legal controller that starts at north green.
        ctrl_pos = 0;
        ctrl_cnt = 0;
        for (int s = 1; s <= 120; s++) begin
            legal();
            if (s == 12) chk("sync_before_s_green", int'(in_sync), 0);
            if (s == 13) chk("sync_at_s_green", int'(in_sync), 1);
            if (s == 48) chk("rounds_at_48", int'(round_count), 0);
            if (s == 49) chk("rounds_at_49", int'(round_count), 1);
            if (s == 96) chk("rounds_at_96", int'(round_count), 1);
            if (s == 97) chk("rounds_at_97", int'(round_count), 2);
            if (s == 120) chk("legal_no_fault", int'(fault), 0);
        end

        // Illegal encoding on north; later legal samples and violations leave it frozen.
        hv = ctrl_heads(ctrl_pos);
        hv[2:0] = 3'b011;
        step(1'b1, 1'b0, hv);
        chk_fault("illegal", 1, 0);
        repeat (10) legal();
        step(1'b1, 1'b0, ALL_RED);
        chk_fault("illegal_held", 1, 0);
        clr_pulse(ctrl_heads(ctrl_pos), "clr1");

        // Conflict: east green alongside south green.
        wait_track_at(2, 3, "conflict_lock");
        hv = ctrl_heads(2);
        hv[8:6] = 3'b001;
        step(1'b1, 1'b0, hv);
        chk_fault("conflict", 2, 1);
        clr_pulse(ctrl_heads(ctrl_pos), "clr2");

        // East green held one sample past its limit.
        wait_track_at(4, 0, "long_lock");
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, ctrl_heads(4));
            if (k == 8) chk("long_at_limit", int'(fault), 0);
        end
        chk_fault("long", 4, 2);
        ctrl_pos = 5;
        ctrl_cnt = 0;
        clr_pulse(ctrl_heads(ctrl_pos), "clr3");

        // South yellow cut to three samples.
        wait_track_at(3, 0, "short_lock");
        repeat (3) step(1'b1, 1'b0, ctrl_heads(3));
        step(1'b1, 1'b0, ctrl_heads(4));
        chk_fault("short", 3, 1);
        ctrl_pos = 4;
        ctrl_cnt = 1;
        clr_pulse(ctrl_heads(ctrl_pos), "clr4");

        // North yellow straight to east green; the clearing edge carries a violation.
        wait_track_at(1, 0, "seq_lock");
        repeat (4) step(1'b1, 1'b0, ctrl_heads(1));
        step(1'b1, 1'b0, ctrl_heads(4));
        chk_fault("sequence", 5, 2);
        ctrl_pos = 4;
        ctrl_cnt = 1;
        hv = ctrl_heads(ctrl_pos);
        hv[2:0] = 3'b011;
        clr_pulse(hv, "clr5");
        wait_track_at(6, 0, "resync");

        // Asynchronous reset while faulted.
        hv = ctrl_heads(ctrl_pos);
        hv[11:9] = 3'b111;
        step(1'b1, 1'b0, hv);
        chk_fault("pre_reset", 1, 3);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_fault", int'(fault), 0);
        chk("async_code", int'(fault_code), 0);
        chk("async_dir", int'(fault_dir), 0);
        chk("async_in_sync", int'(in_sync), 0);
        chk("async_rounds", int'(round_count), 0);
        model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
        step(1'b0, 1'b0, ALL_RED);
        ctrl_pos = 0;
        ctrl_cnt = 0;
        for (int s = 1; s <= 60; s++) begin
            legal();
            if (s == 12) chk("post_reset_presync", int'(in_sync), 0);
            if (s == 13) chk("post_reset_sync", int'(in_sync), 1);
        end

        // Randomized glitches on a legal controller, with random clears.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            c = (m_state == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
            if (r < 5) begin
                hv = 12'($urandom);
            end else if (r < 8) begin
                hv = ALL_RED;
            end else if (r < 14) begin
                hv = ctrl_heads(ctrl_pos);
            end else if (r < 20) begin
                ctrl_pos = (ctrl_pos + 1) % 8;
                ctrl_cnt = 0;
                hv = ctrl_heads(ctrl_pos);
                ctrl_advance();
            end else begin
                hv = ctrl_heads(ctrl_pos);
                ctrl_advance();
            end
            step(1'b1, c, hv);
        end

        // Long clean run to saturate the round counter.
        step(1'b0, 1'b0, ALL_RED);
        ctrl_pos = 0;
        ctrl_cnt = 0;
        for (int s = 1; s <= 12500; s++) legal();
        chk("saturate_rounds", int'(round_count), 255);
        chk("saturate_fault", int'(fault), 0);
        chk("saturate_in_sync", int'(in_sync), 1);

        mon_en = 0;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Independent receiver-side checker for the four-way signal-head outputs of the traffic controller (N, S, E, W lights; 3-bit one-hot: 001 green, 010 yellow, 100 red).
- Samples all four heads every clock and checks encoding, mutual exclusion, phase order (N→S→E→W) and dwell times (green GREEN_CYC, yellow YELLOW_CYC).
- On the first violation it latches a sticky fault code and direction for the intersection supervisor; it also counts completed rounds.

Parameters:
GREEN_CYC, 8, required green dwell in clock samples (2..15)
YELLOW_CYC, 4, required yellow dwell in clock samples (2..15)

Ports:
clk  input  1  clock; all sampling on rising edge
rst_a  input  1  asynchronous, active-low reset; single clock domain
n_lights  input  3  north head, same encoding as controller output
s_lights  input  3  south head
e_lights  input  3  east head
w_lights  input  3  west head
clr_fault  input  1  clears latched fault; acts only in FAULT state
fault  output  1  sticky violation flag
fault_code  output  3  000 none, 001 illegal encoding, 010 conflict, 011 dwell short, 100 dwell long, 101 sequence, 110 all-red
fault_dir  output  2  direction of violation: 00 N, 01 S, 10 E, 11 W
in_sync  output  1  monitor is locked to the phase sequence
round_count  output  8  completed N→S→E→W rounds since sync, saturates at 255

Behaviour:
- All outputs are registered. rst_a low forces immediately: fault=0, fault_code=000, fault_dir=00, in_sync=0, round_count=0, state=SYNC, prev_phase=NONE, dwell=0. Reset asserted mid-operation or mid-fault discards everything.
- Phase decode per sample: exactly one non-red head plus legal one-hot codes gives phase {dir, G/Y}. Response latency: a violation sampled at edge k appears on the outputs right after edge k.
- Checks run every sample in SYNC and TRACK, in this priority order:
  - illegal encoding (any head not in {001, 010, 100}) → 001; dir = lowest-index offending head.
  - more than one non-red head → 010; dir = lowest-index non-red head.
  - all heads red (TRACK only) → 110; dir = expected direction.
  - sequence, short and long checks as defined below.
- SYNC:
  - in_sync=0; prev_phase updated every sample.
  - Enter TRACK on the first sample whose phase is a green that differs from a non-NONE prev_phase. On entry, dwell=1 and expected = that green.
  - Consequence: after a co-reset with the controller, the initial north green is skipped and sync occurs at the first south-green sample.
- TRACK (in_sync=1):
  - Same phase as previous sample: dwell+1. If dwell would exceed the limit for that colour → 100, dir = current direction.
  - Phase change, checked in this order:
    - old dwell ≠ limit → 011, dir = old direction.
    - new phase ≠ successor → 101, dir = new direction. Successors: G_d→Y_d, Y_d→G_(d+1 mod 4).
    - otherwise dwell=1.
  - Transition Y_W→G_N: round_count+1, saturating at 255.
- FAULT:
  - fault=1; code, dir and round_count frozen; in_sync=0. Further violations are ignored (first fault wins).
  - clr_fault=1 at an edge → SYNC with fault=0, code=000, dir=00, prev_phase=NONE, round_count=0. A violation present on that same edge is not flagged; it is re-evaluated from the next sample.
  - clr_fault outside FAULT is ignored.
- Dwell counter is 4 bits and never wraps: the long check fires at limit+1.

Test Plan:
- Co-reset, drive the legal controller pattern (8 G / 4 Y per direction, N→S→E→W) for 120 cycles → in_sync rises after sample 13 (first S green). round_count=1 after sample 49 and 2 after sample 97. fault stays 0.
- After sync, drive n_lights=3'b011 for one sample → fault=1, fault_code=001, fault_dir=00 at the next edge. Later legal inputs leave the code unchanged.
- During S green (tracking), set e_lights=3'b001 with s_lights=001 → fault_code=010, fault_dir=01.
- Hold E green for 9 samples while tracking → code 100, dir 10 at the 9th sample. Separately, a S yellow of 3 samples followed by E green → code 011, dir 01.
- During N yellow→E green (skipping S) → code 101, dir 10. Pulse clr_fault → next edge: fault=0, code=000, in_sync=0, round_count=0. Resync occurs at the next green entry after a phase change.
- While fault=1, assert rst_a low mid-cycle → all outputs 0 without waiting for a clock edge. Release, and the monitor resumes SYNC behaviour.
